// File: rtl/seq_divider_param.sv
// Parametrised multi-cycle restoring divider, one quotient bit per clock,
// with optional signed (truncating) mode, divide-by-zero and overflow flags.
module seq_divider_param #(
   parameter int WIDTH     = 16,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero,
   output logic             overflow
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DIVIDE,
      S_FIXUP,
      S_DONE
   } state_t;

   localparam int               CW      = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             signq_q, signq_d;
   logic             signr_q, signr_d;
   logic             special_q, special_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             ovf_q, ovf_d;

   logic             negDvd, negDvs, isOvf;
   logic [WIDTH-1:0] magDvd, magDvs;
   logic [WIDTH:0]   shifted, trial;

   assign negDvd  = mode_q & dvd_q[WIDTH-1];
   assign negDvs  = mode_q & dvs_q[WIDTH-1];
   assign magDvd  = negDvd ? (~dvd_q + 1'b1) : dvd_q;
   assign magDvs  = negDvs ? (~dvs_q + 1'b1) : dvs_q;
   assign isOvf   = mode_q && (dvd_q == MIN_VAL) && (dvs_q == {WIDTH{1'b1}});

   // The restoring step keeps A below M, so A's top (WIDTH+1'th) bit is
   // always zero and only the low WIDTH bits are stored.
   assign shifted = {a_q, q_q[WIDTH-1]};
   assign trial   = shifted - {1'b0, m_q};

   always_comb begin
      state_d   = state_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      mode_d    = mode_q;
      a_d       = a_q;
      q_d       = q_q;
      m_d       = m_q;
      cnt_d     = cnt_q;
      signq_d   = signq_q;
      signr_d   = signr_q;
      special_d = special_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      dbz_d     = dbz_q;
      ovf_d     = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               mode_d  = SIGNED_EN ? signed_mode : 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            a_d       = '0;
            cnt_d     = '0;
            q_d       = magDvd;
            m_d       = magDvs;
            signq_d   = negDvd ^ negDvs;
            signr_d   = negDvd;
            special_d = 1'b0;
            state_d   = S_DIVIDE;
            // Exceptional results are final here; FIXUP passes them through.
            if (dvs_q == '0) begin
               quot_d    = '1;
               rem_d     = dvd_q;
               dbz_d     = 1'b1;
               ovf_d     = 1'b0;
               special_d = 1'b1;
               state_d   = S_FIXUP;
            end else if (isOvf) begin
               quot_d    = MIN_VAL;
               rem_d     = '0;
               dbz_d     = 1'b0;
               ovf_d     = 1'b1;
               special_d = 1'b1;
               state_d   = S_FIXUP;
            end
         end
         S_DIVIDE: begin
            if (!trial[WIDTH]) begin
               a_d = trial[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               a_d = shifted[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = S_FIXUP;
            end
         end
         S_FIXUP: begin
            if (!special_q) begin
               quot_d = signq_q ? (~q_q + 1'b1) : q_q;
               rem_d  = signr_q ? (~a_q + 1'b1) : a_q;
               dbz_d  = 1'b0;
               ovf_d  = 1'b0;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         dvd_q     <= '0;
         dvs_q     <= '0;
         mode_q    <= 1'b0;
         a_q       <= '0;
         q_q       <= '0;
         m_q       <= '0;
         cnt_q     <= '0;
         signq_q   <= 1'b0;
         signr_q   <= 1'b0;
         special_q <= 1'b0;
         quot_q    <= '0;
         rem_q     <= '0;
         dbz_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         mode_q    <= mode_d;
         a_q       <= a_d;
         q_q       <= q_d;
         m_q       <= m_d;
         cnt_q     <= cnt_d;
         signq_q   <= signq_d;
         signr_q   <= signr_d;
         special_q <= special_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         dbz_q     <= dbz_d;
         ovf_q     <= ovf_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
   assign overflow    = SIGNED_EN ? ovf_q : 1'b0;

endmodule
